// File: rtl/ls_align_unit_if.sv
// Request/response and data-memory bus of the load/store alignment unit.
// The unit connects as slave; the datapath/memory side drives via master.
interface ls_align_unit_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_store;
  logic [1:0]        req_size;
  logic              req_signed;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic              mem_wr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] resp_data;
  logic              resp_err;

  modport slave (
    input  req_valid, req_store, req_size, req_signed, req_addr, req_wdata,
    input  mem_rdata, resp_ready,
    output req_ready, mem_addr, mem_rd, mem_wr, mem_wdata,
    output resp_valid, resp_data, resp_err
  );

  modport master (
    output req_valid, req_store, req_size, req_signed, req_addr, req_wdata,
    output mem_rdata, resp_ready,
    input  req_ready, mem_addr, mem_rd, mem_wr, mem_wdata,
    input  resp_valid, resp_data, resp_err
  );
endinterface

// File: rtl/ls_align_unit.sv
// Load/store alignment unit: sub-word load extract/extend and read-modify-write
// sub-word stores against a word-wide data memory with fixed read latency.
module ls_align_unit #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int MEM_LAT = 1
) (
  input  logic           clk,
  input  logic           reset,
  ls_align_unit_if.slave bus
);
  localparam int OFS_W = $clog2(DATA_W / 8);
  localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  typedef enum logic [2:0] {IDLE, RD, WAIT, WR, RESP} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              store_q, store_d;
  logic [1:0]        size_q, size_d;
  logic              signed_q, signed_d;
  logic [OFS_W-1:0]  ofs_q, ofs_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] resp_data_q, resp_data_d;
  logic              resp_err_q, resp_err_d;

  logic [OFS_W-1:0]  req_ofs;
  logic              req_bad;
  logic [OFS_W+2:0]  shamt;
  logic [15:0]       rd_lane;
  logic [DATA_W-1:0] lane_mask;
  logic [DATA_W-1:0] merged;
  logic [DATA_W-1:0] load_val;

  assign req_ofs = bus.req_addr[OFS_W-1:0];
  assign req_bad = (bus.req_size == 2'b11) ||
                   (bus.req_size == 2'b10 && req_ofs[0]) ||
                   (bus.req_size == 2'b00 && req_ofs != '0);

  // Byte offset of the addressed lane, as a bit shift into the word.
  assign shamt   = {ofs_q, 3'b000};
  assign rd_lane = 16'(bus.mem_rdata >> shamt);

  assign lane_mask = ((size_q == 2'b01) ? {{(DATA_W-8){1'b0}}, 8'hFF}
                                        : {{(DATA_W-16){1'b0}}, 16'hFFFF}) << shamt;
  assign merged    = (bus.mem_rdata & ~lane_mask) | ((wdata_q << shamt) & lane_mask);

  always_comb begin
    unique case (size_q)
      2'b01:   load_val = {{(DATA_W-8){signed_q & rd_lane[7]}}, rd_lane[7:0]};
      2'b10:   load_val = {{(DATA_W-16){signed_q & rd_lane[15]}}, rd_lane};
      default: load_val = bus.mem_rdata;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    store_d     = store_q;
    size_d      = size_q;
    signed_d    = signed_q;
    ofs_d       = ofs_q;
    wdata_d     = wdata_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    resp_data_d = resp_data_q;
    resp_err_d  = resp_err_q;
    unique case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          store_d    = bus.req_store;
          size_d     = bus.req_size;
          signed_d   = bus.req_signed;
          ofs_d      = req_ofs;
          wdata_d    = bus.req_wdata;
          resp_err_d = 1'b0;
          if (req_bad) begin
            resp_err_d  = 1'b1;
            resp_data_d = '0;
            state_d     = RESP;
          end else begin
            mem_addr_d = {bus.req_addr[ADDR_W-1:OFS_W], {OFS_W{1'b0}}};
            if (bus.req_store && bus.req_size == 2'b00) begin
              mem_wdata_d = bus.req_wdata;
              state_d     = WR;
            end else begin
              state_d = RD;
            end
          end
        end
      end
      RD: begin
        cnt_d   = CNT_W'(MEM_LAT - 1);
        state_d = WAIT;
      end
      WAIT: begin
        // Read data is valid in the WAIT cycle where the counter has reached zero.
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (store_q) begin
          mem_wdata_d = merged;
          state_d     = WR;
        end else begin
          resp_data_d = load_val;
          state_d     = RESP;
        end
      end
      WR: begin
        resp_data_d = mem_wdata_q;
        state_d     = RESP;
      end
      RESP: begin
        if (bus.resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      store_q     <= 1'b0;
      size_q      <= 2'b00;
      signed_q    <= 1'b0;
      ofs_q       <= '0;
      wdata_q     <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      resp_data_q <= '0;
      resp_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      store_q     <= store_d;
      size_q      <= size_d;
      signed_q    <= signed_d;
      ofs_q       <= ofs_d;
      wdata_q     <= wdata_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      resp_data_q <= resp_data_d;
      resp_err_q  <= resp_err_d;
    end
  end

  assign bus.req_ready  = (state_q == IDLE);
  assign bus.mem_rd     = (state_q == RD);
  assign bus.mem_wr     = (state_q == WR);
  assign bus.resp_valid = (state_q == RESP);
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.resp_data  = resp_data_q;
  assign bus.resp_err   = resp_err_q;
endmodule

// File: tb/tb_ls_align_unit.sv
// Scoreboard bench for ls_align_unit: directed requests push expected responses,
// a negedge monitor checks strobes, latencies and held responses.
module tb_ls_align_unit;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;

  ls_align_unit_if #(.DATA_W(32), .ADDR_W(32)) bus ();
  ls_align_unit_if #(.DATA_W(32), .ADDR_W(32)) bus3 ();

  ls_align_unit #(.DATA_W(32), .ADDR_W(32), .MEM_LAT(1)) u_dut (
    .clk(clk), .reset(reset), .bus(bus));
  ls_align_unit #(.DATA_W(32), .ADDR_W(32), .MEM_LAT(3)) u_dut3 (
    .clk(clk), .reset(reset), .bus(bus3));

  // Memory model: data valid only in the cycle MEM_LAT after the read strobe.
  logic [31:0] mem_word, mem_word3;
  logic [2:0]  pipe = '0, pipe3 = '0;
  always @(posedge clk) begin
    pipe  <= {pipe[1:0], bus.mem_rd};
    pipe3 <= {pipe3[1:0], bus3.mem_rd};
  end
  assign bus.mem_rdata  = pipe[0]  ? mem_word  : 32'hBAD0BAD0;
  assign bus3.mem_rdata = pipe3[2] ? mem_word3 : 32'hBAD0BAD0;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    string       name;
    logic [31:0] data;
    logic        err;
    int          lat;
    int          nrd;
    int          nwr;
    int          wlat;
    logic [31:0] addr;
  } exp_t;

  exp_t sb[$];
  exp_t e;

  function automatic exp_t mk(input string nm, input logic [31:0] d, input logic er,
                              input int lat, input int nrd, input int nwr, input int wlat,
                              input logic [31:0] ad);
    exp_t x;
    x.name = nm; x.data = d; x.err = er; x.lat = lat;
    x.nrd = nrd; x.nwr = nwr; x.wlat = wlat; x.addr = ad;
    return x;
  endfunction

  int cyc = 0, acc_cyc = 0, nrd = 0, nwr = 0;
  bit seen = 0;
  logic [31:0] held;

  always @(posedge clk) begin
    cyc++;
    if (reset && bus.req_valid && bus.req_ready) begin
      acc_cyc = cyc;
      nrd = 0;
      nwr = 0;
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      if (bus.mem_rd) begin
        nrd++;
        if (sb.size() > 0) chk({sb[0].name, " rd mem_addr"}, bus.mem_addr, sb[0].addr);
      end
      if (bus.mem_wr) begin
        nwr++;
        if (sb.size() > 0) begin
          chk({sb[0].name, " mem_wdata"}, bus.mem_wdata, sb[0].data);
          chk({sb[0].name, " wr mem_addr"}, bus.mem_addr, sb[0].addr);
          chk({sb[0].name, " wr_lat"}, 32'(cyc - acc_cyc + 1), 32'(sb[0].wlat));
        end
      end
      if (bus.resp_valid && !seen) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_resp: got 0x%08h expected no response", bus.resp_data);
        end else begin
          e = sb.pop_front();
          chk({e.name, " resp_data"}, bus.resp_data, e.data);
          chk({e.name, " resp_err"}, 32'(bus.resp_err), 32'(e.err));
          chk({e.name, " resp_lat"}, 32'(cyc - acc_cyc + 1), 32'(e.lat));
          chk({e.name, " n_rd"}, 32'(nrd), 32'(e.nrd));
          chk({e.name, " n_wr"}, 32'(nwr), 32'(e.nwr));
        end
        seen = 1;
        held = bus.resp_data;
      end else if (bus.resp_valid) begin
        chk("hold resp_data", bus.resp_data, held);
        chk("hold req_ready", 32'(bus.req_ready), 32'd0);
      end
      if (!bus.resp_valid) seen = 0;
    end
  end

  task automatic issue(input logic st, input logic [1:0] sz, input logic sg,
                       input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rw,
                       input exp_t x);
    int n = 0;
    while (!bus.req_ready && n < 50) begin @(negedge clk); n++; end
    bus.req_store  = st;
    bus.req_size   = sz;
    bus.req_signed = sg;
    bus.req_addr   = a;
    bus.req_wdata  = wd;
    mem_word       = rw;
    sb.push_back(x);
    bus.req_valid  = 1'b1;
    @(negedge clk);
    bus.req_valid  = 1'b0;
    n = 0;
    while ((sb.size() != 0 || bus.resp_valid) && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) begin
      checks++;
      errors++;
      $display("FAIL %s timeout: got no completed response expected one", x.name);
      sb.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset = 1'b0;
    bus.req_valid = 0; bus.req_store = 0; bus.req_size = 0; bus.req_signed = 0;
    bus.req_addr = 0; bus.req_wdata = 0; bus.resp_ready = 1;
    bus3.req_valid = 0; bus3.req_store = 0; bus3.req_size = 0; bus3.req_signed = 0;
    bus3.req_addr = 0; bus3.req_wdata = 0; bus3.resp_ready = 1;
    mem_word = 0; mem_word3 = 0;
    repeat (3) @(negedge clk);
    chk("rst req_ready", 32'(bus.req_ready), 32'd1);
    chk("rst resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("rst mem_rd", 32'(bus.mem_rd), 32'd0);
    chk("rst mem_wr", 32'(bus.mem_wr), 32'd0);
    chk("rst resp_err", 32'(bus.resp_err), 32'd0);
    chk("rst resp_data", bus.resp_data, 32'd0);
    chk("rst mem_addr", bus.mem_addr, 32'd0);
    chk("rst mem_wdata", bus.mem_wdata, 32'd0);
    reset = 1'b1;
    @(negedge clk);

    issue(0, 2'b01, 1, 32'h103, 32'h0, 32'h80112233,
          mk("t1_ldb_s", 32'hFFFFFF80, 0, 3, 1, 0, 0, 32'h100));
    issue(0, 2'b10, 0, 32'h102, 32'h0, 32'h80017FFF,
          mk("t2_ldh_u", 32'h00008001, 0, 3, 1, 0, 0, 32'h100));
    issue(0, 2'b10, 1, 32'h102, 32'h0, 32'h80017FFF,
          mk("t2_ldh_s", 32'hFFFF8001, 0, 3, 1, 0, 0, 32'h100));
    issue(1, 2'b01, 0, 32'h201, 32'h000000AB, 32'h11223344,
          mk("t3_stb", 32'h1122AB44, 0, 4, 1, 1, 3, 32'h200));
    issue(1, 2'b00, 0, 32'h300, 32'hDEADBEEF, 32'h0,
          mk("t4_stw", 32'hDEADBEEF, 0, 2, 0, 1, 1, 32'h300));
    issue(0, 2'b10, 0, 32'h101, 32'h0, 32'h0,
          mk("t5_half_mis", 32'h0, 1, 1, 0, 0, 0, 32'h0));
    issue(0, 2'b11, 0, 32'h100, 32'h0, 32'h0,
          mk("t5_rsvd", 32'h0, 1, 1, 0, 0, 0, 32'h0));
    issue(1, 2'b00, 0, 32'h102, 32'h12345678, 32'h0,
          mk("word_mis", 32'h0, 1, 1, 0, 0, 0, 32'h0));
    issue(0, 2'b00, 0, 32'hFFFF0104, 32'h0, 32'hCAFEF00D,
          mk("ldw_hiaddr", 32'hCAFEF00D, 0, 3, 1, 0, 0, 32'hFFFF0104));
    issue(0, 2'b01, 0, 32'h100, 32'h0, 32'h80112233,
          mk("ldb_u_k0", 32'h00000033, 0, 3, 1, 0, 0, 32'h100));
    issue(1, 2'b10, 0, 32'h402, 32'hFFFFBEEF, 32'h11223344,
          mk("sth_k2", 32'hBEEF3344, 0, 4, 1, 1, 3, 32'h400));

    // Response held for three cycles with resp_ready low.
    bus.resp_ready = 1'b0;
    fork
      issue(0, 2'b01, 0, 32'h101, 32'h0, 32'h12345678,
            mk("t6_hold", 32'h00000056, 0, 3, 1, 0, 0, 32'h100));
      begin
        n = 0;
        @(negedge clk);
        while (!bus.resp_valid && n < 20) begin @(negedge clk); n++; end
        repeat (3) @(negedge clk);
        bus.resp_ready = 1'b1;
      end
    join

    // Reset during WAIT of a sub-word store: store must be dropped.
    mem_word = 32'h11223344;
    bus.req_store = 1; bus.req_size = 2'b01; bus.req_signed = 0;
    bus.req_addr = 32'h205; bus.req_wdata = 32'h000000CD;
    bus.req_valid = 1'b1;
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("t6_rst req_ready", 32'(bus.req_ready), 32'd1);
    chk("t6_rst mem_wr", 32'(bus.mem_wr), 32'd0);
    reset = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("t6_rst no mem_wr", 32'(bus.mem_wr), 32'd0);
      chk("t6_rst no resp", 32'(bus.resp_valid), 32'd0);
    end

    // MEM_LAT=3 instance repeats the signed byte load.
    mem_word3 = 32'h80112233;
    bus3.req_store = 0; bus3.req_size = 2'b01; bus3.req_signed = 1;
    bus3.req_addr = 32'h103; bus3.req_valid = 1'b1;
    @(negedge clk);
    bus3.req_valid = 1'b0;
    n = 1;
    while (!bus3.resp_valid && n < 20) begin @(negedge clk); n++; end
    chk("lat3 resp_lat", 32'(n), 32'd5);
    chk("lat3 resp_data", bus3.resp_data, 32'hFFFFFF80);
    chk("lat3 resp_err", 32'(bus3.resp_err), 32'd0);
    chk("lat3 mem_addr", bus3.mem_addr, 32'h100);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
